mul_approx_iter: RTL and testbench

//  Iterative, parametrised unsigned approximate multiplier: WIDTH x WIDTH -> 2*WIDTH product.

---
 rtl/mul_approx_iter.sv | 110 +++++++++++
 tb/tb_mul_approx_iter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_approx_iter.sv
// Iterative unsigned approximate multiplier: WIDTH x WIDTH -> 2*WIDTH.
// One partial-product row is added per clock. Columns below the runtime
// truncation point t are dropped, so t=0 gives the exact product.
// Operands are captured at accept and held in local registers, so the
// a/b/trunc inputs may change freely while a product is being built.
module mul_approx_iter #(
    parameter int WIDTH     = 8,
    parameter int TRUNC_W   = 4,
    parameter int MAX_TRUNC = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [TRUNC_W-1:0]   trunc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [TRUNC_W-1:0]   trunc_used
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);
    // If the trunc port is too narrow to express MAX_TRUNC, the port range
    // itself is the effective ceiling.
    localparam int T_TOP = (1 << TRUNC_W) - 1;
    localparam int T_LIM = (MAX_TRUNC > T_TOP) ? T_TOP : MAX_TRUNC;
    localparam logic [TRUNC_W-1:0] MAX_T    = TRUNC_W'(T_LIM);
    localparam logic [CNT_W-1:0]   LAST_ROW = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [WIDTH-1:0]    a_reg;
    logic [WIDTH-1:0]    b_reg;
    logic [PW-1:0]       acc;
    logic [CNT_W-1:0]    row;
    logic [WIDTH-1:0]    mask;
    logic [PW-1:0]       row_val;
    logic [TRUNC_W-1:0]  t_clamped;
    logic                accept;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign t_clamped = (trunc > MAX_T) ? MAX_T : trunc;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state: fixed WIDTH-row walk in CALC, then hold in DONE until taken.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = CALC;
            CALC:    if (row == LAST_ROW) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Row mask: keep multiplicand bit i of row j only when column i+j >= t.
    always_comb begin
        mask = '0;
        for (int i = 0; i < WIDTH; i++)
            mask[i] = ((i + int'(row)) >= int'(trunc_used));
    end

    // Current partial-product row, already shifted to its column.
    always_comb begin
        row_val = '0;
        if (b_reg[row])
            row_val = PW'(a_reg & mask) << row;
    end

    // Datapath: capture at accept, accumulate rows in CALC, publish on the last
    // row so product stays frozen for the whole DONE phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            acc        <= '0;
            row        <= '0;
            product    <= '0;
            trunc_used <= '0;
        end else if (accept) begin
            a_reg      <= a;
            b_reg      <= b;
            acc        <= '0;
            row        <= '0;
            trunc_used <= t_clamped;
        end else if (state == CALC) begin
            acc <= acc + row_val;
            row <= row + 1'b1;
            if (row == LAST_ROW)
                product <= acc + row_val;
        end
    end

endmodule

// File: tb/tb_mul_approx_iter.sv
// Directed + random bench for mul_approx_iter (WIDTH=8, MAX_TRUNC=8).
// A negedge monitor pushes the golden result on every accept and pops/compares
// on every output handshake; directed steps add targeted checks on top.
module tb_mul_approx_iter;

    localparam int WIDTH     = 8;
    localparam int TRUNC_W   = 4;
    localparam int MAX_TRUNC = 8;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [TRUNC_W-1:0] trunc;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
    logic [TRUNC_W-1:0] trunc_used;

    typedef struct {
        logic [2*WIDTH-1:0] p;
        logic [TRUNC_W-1:0] t;
    } exp_t;

    exp_t               q[$];
    int                 checks   = 0;
    int                 failures = 0;
    int                 cyc      = 0;
    int                 acc_cyc  = 0;
    logic               prev_ov  = 1'b0;
    logic [2*WIDTH-1:0] last_prod = '0;
    logic [2*WIDTH-1:0] hold;

    mul_approx_iter #(
        .WIDTH(WIDTH), .TRUNC_W(TRUNC_W), .MAX_TRUNC(MAX_TRUNC)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .trunc(trunc),
        .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .trunc_used(trunc_used)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [TRUNC_W-1:0] clampt(input logic [TRUNC_W-1:0] t);
        return (int'(t) > MAX_TRUNC) ? TRUNC_W'(MAX_TRUNC) : t;
    endfunction

    // Golden model: straight double sum over surviving partial-product bits.
    function automatic logic [2*WIDTH-1:0] model(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y,
                                                  input int t);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < WIDTH; i++)
            for (int j = 0; j < WIDTH; j++)
                if (x[i] && y[j] && (i + j >= t))
                    s = s + (32'd1 << (i + j));
        return s[2*WIDTH-1:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Issue one operation; returns #1 after the accepting edge.
    task automatic do_op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic [TRUNC_W-1:0] it, input bit rnd);
        int n;
        if (rnd) begin
            repeat ($urandom_range(0, 3)) begin
                a = WIDTH'($urandom); b = WIDTH'($urandom); trunc = TRUNC_W'($urandom);
                out_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
        end
        a = ia; b = ib; trunc = it; in_valid = 1'b1;
        n = 0;
        while (!in_ready) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
            if (n > 60) begin
                chk("accept_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom);
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 || out_valid) begin
            @(posedge clk); #1;
            n++;
            if (n > 100) begin
                chk("drain_timeout", 32'd1, 32'd0);
                break;
            end
        end
    endtask

    initial begin
        exp_t e;
        int   n;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; trunc = '0; out_ready = 1'b1;

        // Scoreboard monitor: everything sampled mid-cycle, away from the edge.
        fork
            forever begin
                @(negedge clk);
                if (!rst && in_valid && in_ready) begin
                    e.t = clampt(trunc);
                    e.p = model(a, b, int'(e.t));
                    q.push_back(e);
                    acc_cyc = cyc + 1;
                end
                if (!rst && out_valid && !prev_ov)
                    chk("latency", 32'(cyc - acc_cyc), 32'(WIDTH));
                if (!rst && out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_out", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("product", 32'(product), 32'(e.p));
                        chk("trunc_used", 32'(trunc_used), 32'(e.t));
                        last_prod = product;
                    end
                end
                prev_ov = out_valid;
            end
        join_none

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        chk("rst_trunc_used", 32'(trunc_used), 32'd0);
        rst = 1'b0;

        // Exact and truncated directed cases.
        do_op(8'd255, 8'd255, 4'd0, 1'b0); drain();
        chk("exact_255x255", 32'(last_prod), 32'd65025);
        do_op(8'd255, 8'd255, 4'd4, 1'b0); drain();
        chk("t4_255x255", 32'(last_prod), 32'd64976);
        do_op(8'd15, 8'd15, 4'd4, 1'b0); drain();
        chk("t4_15x15", 32'(last_prod), 32'd176);

        // Clamp plus back-pressure.
        out_ready = 1'b0;
        do_op(8'd255, 8'd255, 4'd15, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("bp_valid_seen", 32'(out_valid), 32'd1);
        hold = product;
        chk("clamp_product", 32'(hold), 32'h0000F700);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_product_hold", 32'(product), 32'(hold));
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        chk("clamp_trunc_used", 32'(trunc_used), 32'd8);
        chk("clamp_low_byte", 32'(product[7:0]), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_release_q", 32'(q.size()), 32'd0);
        out_ready = 1'b1;

        // Reset on the third CALC cycle discards the operation.
        do_op(8'd200, 8'd100, 4'd0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        q.delete();
        @(posedge clk); #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_product", 32'(product), 32'd0);
        rst = 1'b0;
        do_op(8'd3, 8'd5, 4'd0, 1'b0); drain();
        chk("after_rst_3x5", 32'(last_prod), 32'd15);

        // Random traffic with gaps and back-pressure; corners every few ops.
        for (int k = 0; k < 400; k++) begin
            logic [WIDTH-1:0]   ra, rb;
            logic [TRUNC_W-1:0] rt;
            ra = WIDTH'($urandom); rb = WIDTH'($urandom); rt = TRUNC_W'($urandom);
            case (k % 8)
                1: ra = '0;
                3: rb = '0;
                5: rt = '0;
                7: begin ra = '1; rb = '1; end
                default: ;
            endcase
            do_op(ra, rb, rt, 1'b1);
        end
        drain();
        chk("final_queue_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
